// File: rtl/boot_loader_pkg.sv
// boot_loader shared types.
// Loader FSM state encoding.
package boot_loader_pkg;

  localparam int STATE_W = 3;

  typedef enum logic [STATE_W-1:0] {
    S_IDLE,
    S_LOAD,
    S_VERIFY,
    S_RUN,
    S_ERR
  } state_e;

endpackage

// File: rtl/boot_checksum.sv
// boot_checksum: modular running sum.
// Clear wins over enable.
module boot_checksum #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         en,
  input  logic [W-1:0] add,
  output logic [W-1:0] sum
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      sum <= '0;
    else if (clr)
      sum <= '0;
    else if (en)
      sum <= sum + add;
  end

endmodule

// File: rtl/boot_loader.sv
// boot_loader: streams an image into ram,
// optionally verifies it, then hands the bus to the cpu.
module boot_loader
  import boot_loader_pkg::*;
#(
  parameter int MEM_WIDTH = 8,
  parameter int WORD_SIZE = 8,
  parameter int VERIFY    = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [WORD_SIZE-1:0] base_addr,
  input  logic [WORD_SIZE:0]   load_len,
  input  logic                 in_valid,
  input  logic [MEM_WIDTH-1:0] in_data,
  output logic                 in_ready,
  input  logic [WORD_SIZE-1:0] cpu_addr,
  input  logic                 cpu_wr_en,
  input  logic [MEM_WIDTH-1:0] cpu_wdata,
  output logic [MEM_WIDTH-1:0] cpu_rdata,
  output logic [WORD_SIZE-1:0] ram_addr,
  output logic                 ram_wr_en,
  output logic [MEM_WIDTH-1:0] ram_wdata,
  input  logic [MEM_WIDTH-1:0] ram_rdata,
  output logic                 cpu_rst,
  output logic                 busy,
  output logic                 done,
  output logic                 err,
  output logic [MEM_WIDTH-1:0] checksum
);

  state_e               state;
  logic [WORD_SIZE-1:0] base_q;
  logic [WORD_SIZE:0]   len_q;
  logic [WORD_SIZE:0]   cnt;
  logic [MEM_WIDTH-1:0] ver_sum;
  logic [MEM_WIDTH-1:0] ver_final;
  logic [WORD_SIZE-1:0] cnt_addr;
  logic                 start_ok;
  logic                 accept;
  logic                 last_word;
  logic                 ver_en;

  assign start_ok  = start &&
                     (state inside {S_IDLE, S_RUN, S_ERR});
  assign accept    = (state == S_LOAD) && in_valid && in_ready;
  assign last_word = (cnt == len_q - 1'b1);
  assign cnt_addr  = base_q + cnt[WORD_SIZE-1:0];
  // verify reads lag their address by one cycle
  assign ver_en    = (state == S_VERIFY) && (cnt != '0);
  assign ver_final = ver_sum + ram_rdata;

  boot_checksum #(.W(MEM_WIDTH)) u_load_sum (
    .clk (clk),
    .rst (rst),
    .clr (start_ok),
    .en  (accept),
    .add (in_data),
    .sum (checksum)
  );

  boot_checksum #(.W(MEM_WIDTH)) u_ver_sum (
    .clk (clk),
    .rst (rst),
    .clr (start_ok),
    .en  (ver_en),
    .add (ram_rdata),
    .sum (ver_sum)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= S_IDLE;
      base_q   <= '0;
      len_q    <= '0;
      cnt      <= '0;
      in_ready <= 1'b0;
      cpu_rst  <= 1'b1;
      busy     <= 1'b0;
      done     <= 1'b0;
      err      <= 1'b0;
    end else begin
      unique case (state)
        S_IDLE, S_RUN, S_ERR: begin
          if (start) begin
            base_q <= base_addr;
            len_q  <= load_len;
            cnt    <= '0;
            err    <= 1'b0;
            if (load_len == '0) begin
              state   <= S_RUN;
              cpu_rst <= 1'b0;
              done    <= 1'b1;
            end else begin
              state    <= S_LOAD;
              in_ready <= 1'b1;
              busy     <= 1'b1;
              cpu_rst  <= 1'b1;
              done     <= 1'b0;
            end
          end
        end
        S_LOAD: begin
          if (accept) begin
            if (last_word) begin
              in_ready <= 1'b0;
              cnt      <= '0;
              if (VERIFY != 0) begin
                state <= S_VERIFY;
              end else begin
                state   <= S_RUN;
                busy    <= 1'b0;
                done    <= 1'b1;
                cpu_rst <= 1'b0;
              end
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
        end
        S_VERIFY: begin
          if (cnt == len_q) begin
            busy <= 1'b0;
            cnt  <= '0;
            if (ver_final == checksum) begin
              state   <= S_RUN;
              done    <= 1'b1;
              cpu_rst <= 1'b0;
            end else begin
              state <= S_ERR;
              err   <= 1'b1;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  always_comb begin
    ram_addr  = '0;
    ram_wr_en = 1'b0;
    ram_wdata = '0;
    unique case (1'b1)
      state == S_RUN: begin
        ram_addr  = cpu_addr;
        ram_wr_en = cpu_wr_en;
        ram_wdata = cpu_wdata;
      end
      state == S_LOAD: begin
        ram_addr  = cnt_addr;
        ram_wr_en = accept;
        ram_wdata = in_data;
      end
      state == S_VERIFY: begin
        ram_addr = (cnt < len_q) ? cnt_addr : '0;
      end
      default: ;
    endcase
  end

  assign cpu_rdata = (state == S_RUN) ? ram_rdata : '0;

endmodule

// File: tb/tb_boot_loader.sv
// tb_boot_loader: directed load/verify/run scenarios
// against a phase model and write scoreboard.
module tb_boot_loader;

  localparam int VERIFY = 1;

  typedef struct packed {
    logic [7:0] a;
    logic [7:0] d;
  } wr_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic [7:0] base_addr = '0;
  logic [8:0] load_len = '0;
  logic       in_valid = 1'b0;
  logic [7:0] in_data = '0;
  logic       in_ready;
  logic [7:0] cpu_addr = '0;
  logic       cpu_wr_en = 1'b0;
  logic [7:0] cpu_wdata = '0;
  logic [7:0] cpu_rdata;
  logic [7:0] ram_addr;
  logic       ram_wr_en;
  logic [7:0] ram_wdata;
  logic [7:0] ram_rdata = '0;
  logic       cpu_rst;
  logic       busy;
  logic       done;
  logic       err;
  logic [7:0] checksum;

  logic [7:0] mem [0:255];
  logic [7:0] img [0:255];
  logic       flip_en = 1'b0;
  logic [7:0] flip_addr = '0;

  // model state
  logic       m_done = 1'b0;
  logic       m_err = 1'b0;
  logic       m_busy = 1'b0;
  logic       m_inready = 1'b0;
  logic [7:0] m_sum = '0;
  wr_t        exp_q [$];
  wr_t        e;

  int n_chk = 0;
  int n_pass = 0;
  int cyc = 0;
  int t_start = 0;
  bit chk_en = 1'b0;

  boot_loader #(
    .MEM_WIDTH (8),
    .WORD_SIZE (8),
    .VERIFY    (VERIFY)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .base_addr (base_addr),
    .load_len  (load_len),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .cpu_addr  (cpu_addr),
    .cpu_wr_en (cpu_wr_en),
    .cpu_wdata (cpu_wdata),
    .cpu_rdata (cpu_rdata),
    .ram_addr  (ram_addr),
    .ram_wr_en (ram_wr_en),
    .ram_wdata (ram_wdata),
    .ram_rdata (ram_rdata),
    .cpu_rst   (cpu_rst),
    .busy      (busy),
    .done      (done),
    .err       (err),
    .checksum  (checksum)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // synchronous ram with optional read corruption
  always @(posedge clk) begin
    if (ram_wr_en) mem[ram_addr] <= ram_wdata;
    ram_rdata <= mem[ram_addr] ^
      ((flip_en && ram_addr == flip_addr) ? 8'h01 : 8'h00);
  end

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h",
                  name, act, exp);
  endtask

  always @(negedge clk) begin
    if (chk_en && !rst) begin
      chk("done", done, m_done);
      chk("err", err, m_err);
      chk("busy", busy, m_busy);
      chk("cpu_rst", cpu_rst, !m_done);
      chk("in_ready", in_ready, m_inready);
      if (m_inready) begin
        chk("load_wr_en", ram_wr_en, in_valid);
        if (in_valid) begin
          if (exp_q.size() == 0) begin
            n_chk++;
            $display("FAIL load_extra: got write %0h, none expected",
                     ram_addr);
          end else begin
            e = exp_q.pop_front();
            chk("load_addr", ram_addr, e.a);
            chk("load_data", ram_wdata, e.d);
          end
        end
      end else begin
        chk("checksum", checksum, m_sum);
      end
      if (m_done) begin
        chk("pt_addr", ram_addr, cpu_addr);
        chk("pt_wr_en", ram_wr_en, cpu_wr_en);
        chk("pt_wdata", ram_wdata, cpu_wdata);
        chk("pt_rdata", cpu_rdata, ram_rdata);
      end else begin
        chk("cpu_rdata_off", cpu_rdata, 0);
        if (!m_inready) chk("bus_idle", ram_wr_en, 0);
      end
    end
  end

  task automatic do_load(input logic [7:0] base, input int len,
                         input bit stall, input bit flip,
                         input bit poke);
    logic [7:0] s;
    wr_t w;
    int k;
    bit ph;
    s = '0;
    for (int i = 0; i < len; i++) begin
      w.a = base + 8'(i);
      w.d = img[i];
      exp_q.push_back(w);
      s = s + img[i];
    end
    start = 1'b1;
    base_addr = base;
    load_len = 9'(len);
    flip_en = flip;
    flip_addr = base + 8'd2;
    @(posedge clk); #1;
    start = 1'b0;
    t_start = cyc;
    m_err = 1'b0;
    if (len == 0) begin
      m_done = 1'b1;
      m_sum = '0;
      return;
    end
    m_done = 1'b0;
    m_busy = 1'b1;
    m_inready = 1'b1;
    base_addr = 8'hC0;
    k = 0;
    ph = 1'b0;
    while (k < len) begin
      in_valid = !(stall && ph);
      in_data = img[k];
      start = poke && (k == 1);
      ph = !ph;
      @(posedge clk); #1;
      if (in_valid) k++;
    end
    in_valid = 1'b0;
    start = 1'b0;
    m_inready = 1'b0;
    m_sum = s;
    if (VERIFY != 0) begin
      repeat (len + 1) @(posedge clk);
      #1;
    end
    m_busy = 1'b0;
    m_done = !flip;
    m_err = flip;
    flip_en = 1'b0;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_in_ready"}, in_ready, 0);
    chk({tag, "_cpu_rst"}, cpu_rst, 1);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_err"}, err, 0);
    chk({tag, "_wr_en"}, ram_wr_en, 0);
    chk({tag, "_addr"}, ram_addr, 0);
    chk({tag, "_wdata"}, ram_wdata, 0);
    chk({tag, "_checksum"}, checksum, 0);
    chk({tag, "_cpu_rdata"}, cpu_rdata, 0);
  endtask

  initial begin
    wr_t w;
    for (int i = 0; i < 256; i++) begin
      mem[i] = '0;
      img[i] = '0;
    end
    #22;
    chk_reset_outputs("rst0");
    @(posedge clk); #1;
    rst = 1'b0;
    chk_en = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    // basic load with verify
    img[0] = 8'h01; img[1] = 8'h02;
    img[2] = 8'h03; img[3] = 8'h04;
    do_load(8'h10, 4, 0, 0, 0);
    chk("basic_latency", cyc - t_start, 9);
    chk("basic_sum", checksum, 8'h0A);
    chk("basic_m10", mem[8'h10], 8'h01);
    chk("basic_m13", mem[8'h13], 8'h04);
    chk("basic_done", done, 1);

    // wrap with stalls
    img[0] = 8'h10; img[1] = 8'h20;
    img[2] = 8'h30; img[3] = 8'h40;
    do_load(8'hFE, 4, 1, 0, 0);
    chk("wrap_sum", checksum, 8'hA0);
    chk("wrap_mfe", mem[8'hFE], 8'h10);
    chk("wrap_mff", mem[8'hFF], 8'h20);
    chk("wrap_m00", mem[8'h00], 8'h30);
    chk("wrap_m01", mem[8'h01], 8'h40);

    // verify failure, then recovery
    img[0] = 8'h05; img[1] = 8'h06;
    img[2] = 8'h07; img[3] = 8'h08;
    do_load(8'h80, 4, 0, 1, 0);
    chk("vfail_err", err, 1);
    chk("vfail_cpu_rst", cpu_rst, 1);
    repeat (3) @(posedge clk);
    #1;
    do_load(8'h80, 4, 0, 0, 0);
    chk("vfix_done", done, 1);
    chk("vfix_sum", checksum, 8'h1A);

    // zero length, then reload from RUN with a stray start
    do_load(8'h30, 0, 0, 0, 0);
    chk("zero_done", done, 1);
    chk("zero_sum", checksum, 0);
    cpu_addr = 8'h77;
    cpu_wdata = 8'h55;
    cpu_wr_en = 1'b1;
    img[0] = 8'h01; img[1] = 8'h01; img[2] = 8'h01;
    do_load(8'h30, 3, 0, 0, 1);
    chk("reload_sum", checksum, 8'h03);
    chk("reload_m32", mem[8'h32], 8'h01);
    cpu_wr_en = 1'b0;

    // cpu pass-through
    cpu_addr = 8'h20;
    cpu_wdata = 8'hAA;
    cpu_wr_en = 1'b1;
    @(posedge clk); #1;
    cpu_wr_en = 1'b0;
    @(posedge clk); #1;
    chk("run_read", cpu_rdata, 8'hAA);
    chk("run_cpu_rst", cpu_rst, 0);

    // full-depth image
    for (int i = 0; i < 256; i++) img[i] = 8'(i);
    do_load(8'h05, 256, 0, 0, 0);
    chk("full_sum", checksum, 8'h80);
    chk("full_m04", mem[8'h04], 8'hFF);
    chk("full_m05", mem[8'h05], 8'h00);

    // async reset mid-load
    start = 1'b1;
    base_addr = 8'h40;
    load_len = 9'd5;
    @(posedge clk); #1;
    start = 1'b0;
    m_done = 1'b0;
    m_busy = 1'b1;
    m_inready = 1'b1;
    w.a = 8'h40; w.d = 8'h11; exp_q.push_back(w);
    w.a = 8'h41; w.d = 8'h22; exp_q.push_back(w);
    in_valid = 1'b1;
    in_data = 8'h11;
    @(posedge clk); #1;
    in_data = 8'h22;
    @(posedge clk); #1;
    in_data = 8'h33;
    #1 rst = 1'b1;
    #1;
    chk_reset_outputs("arst");
    m_done = 1'b0;
    m_busy = 1'b0;
    m_inready = 1'b0;
    m_err = 1'b0;
    m_sum = '0;
    in_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("arst_m40", mem[8'h40], 8'h11);
    chk("arst_m41", mem[8'h41], 8'h22);
    chk("arst_m42", mem[8'h42], 8'h3D);
    chk("queue_drained", exp_q.size(), 0);

    chk_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/boot_loader.md
Name: boot_loader

Overview:
- Sits between the cpu and the ram on the shared address/data bus.
- Streams a program image from an external valid/ready source into the ram at a programmable base address, with optional readback-checksum verification.
- Holds the cpu in reset until the image is loaded and verified, then hands the ram bus to the cpu.
- A new start request reclaims the bus and reloads.

Parameters:
- MEM_WIDTH, 8, ram data word width in bits.
- WORD_SIZE, 8, ram address width in bits; depth = 2**WORD_SIZE.
- VERIFY, 1, 1 = readback checksum pass after load; 0 = go straight to RUN.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- rst  in  1  reset, asynchronous, active-high.
- start  in  1  single-cycle pulse requesting a (re)load; honoured in IDLE, RUN, ERR; ignored in LOAD/VERIFY.
- base_addr  in  WORD_SIZE  first ram address written; sampled when start is accepted.
- load_len  in  WORD_SIZE+1  number of words to load, 0..2**WORD_SIZE; sampled when start is accepted.
- in_valid  in  1  source word valid.
- in_data  in  MEM_WIDTH  source word.
- in_ready  out  1  loader accepts in_data this cycle.
- cpu_addr  in  WORD_SIZE  cpu address bus.
- cpu_wr_en  in  1  cpu write enable.
- cpu_wdata  in  MEM_WIDTH  cpu write data.
- cpu_rdata  out  MEM_WIDTH  ram read data returned to the cpu.
- ram_addr  out  WORD_SIZE  ram address (drives wr_addr and rd_addr).
- ram_wr_en  out  1  ram write enable.
- ram_wdata  out  MEM_WIDTH  ram write data.
- ram_rdata  in  MEM_WIDTH  ram read data; valid 1 cycle after ram_addr is presented.
- cpu_rst  out  1  reset to cpu, active-high.
- busy  out  1  high in LOAD or VERIFY.
- done  out  1  high in RUN.
- err  out  1  high in ERR (verify mismatch).
- checksum  out  MEM_WIDTH  sum mod 2**MEM_WIDTH of loaded words; held after load.

Behaviour:
- Reset (async): state=IDLE; cpu_rst=1; in_ready=0; ram_wr_en=0; ram_addr=0; ram_wdata=0; busy=0; done=0; err=0; checksum=0; internal counters 0.
- States: IDLE, LOAD, VERIFY, RUN, ERR.
- IDLE/RUN/ERR + start:
  - Latch base_addr and load_len.
  - Clear checksum and the word counter; cpu_rst=1 from the next cycle.
  - Go to LOAD, or to RUN directly if load_len==0 (checksum stays 0).
- LOAD:
  - in_ready=1; the bus is owned by the loader.
  - A word is accepted when in_valid & in_ready. In that same cycle: ram_wr_en=1, ram_addr=(base+cnt) mod 2**WORD_SIZE, ram_wdata=in_data.
  - Each accepted word adds to checksum (mod 2**MEM_WIDTH) and increments cnt.
  - No accept -> ram_wr_en=0.
  - On the accept with cnt==load_len-1: in_ready drops next cycle; go to VERIFY if VERIFY=1, else RUN.
  - Throughput: 1 word/cycle.
- VERIFY:
  - For i=0..load_len-1, one address per cycle: ram_addr=(base+i) mod depth, ram_wr_en=0.
  - ram_rdata for address i is accumulated one cycle later into a shadow sum; duration load_len+1 cycles.
  - Final shadow sum == checksum -> RUN; otherwise -> ERR.
- RUN: cpu_rst=0; done=1; ram_addr=cpu_addr, ram_wr_en=cpu_wr_en, ram_wdata=cpu_wdata (combinational pass-through).
- cpu_rdata=ram_rdata in RUN, 0 in all other states.
- ERR: err=1; cpu_rst=1; bus idle (ram_wr_en=0). Left only by start or rst.
- Address wrap: base+cnt wraps modulo depth. load_len=2**WORD_SIZE writes every location exactly once.
- Source stall: in_valid low for any number of cycles leaves state, cnt and checksum unchanged.
- start during LOAD/VERIFY: ignored.
- rst mid-LOAD: partial image is left in the ram; loader returns to IDLE and cpu stays in reset.
- cpu_rst is a registered output: first RUN cycle it falls; on a start accepted in RUN it rises the next cycle. cpu bus inputs are ignored outside RUN.

Decomposition:
- Package boot_loader_pkg: state enum (IDLE, LOAD, VERIFY, RUN, ERR) and the state encoding width.
- One sub-module, boot_checksum: MEM_WIDTH modular accumulator with clear and enable, instantiated twice (load sum, verify sum).

Test Plan:
- Basic load: WORD_SIZE=8, MEM_WIDTH=8, base=0x10, len=4, words 0x01,0x02,0x03,0x04 back-to-back -> writes at 0x10..0x13; checksum=0x0A; VERIFY passes; done=1 and cpu_rst=0 on cycle 4+5 after start.
- Wrap and stall: base=0xFE, len=4, in_valid toggling 1,0,1,0,... -> writes to 0xFE, 0xFF, 0x00, 0x01 only on valid cycles; cnt frozen while stalled.
- Verify failure: force ram_rdata bit flip at address base+2 during VERIFY -> err=1, cpu_rst stays 1; a subsequent start with a clean ram recovers to RUN.
- Zero length and reload: start with len=0 -> RUN next cycle with checksum=0. Then a start while in RUN -> cpu_rst=1 next cycle, bus returns to the loader, new image loaded.
- Async reset mid-LOAD: assert rst between clock edges after 2 of 5 words -> all outputs at reset values immediately; in_ready=0; cpu_rst=1.
- RUN pass-through: cpu writes 0xAA to 0x20, then reads 0x20 -> ram_wr_en follows cpu_wr_en; cpu_rdata=0xAA one cycle after the read address.
